// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and op-code decode for the shared-ALU arbiter.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [1:0] operation;
    logic       carry_in;
    logic       illegal;
  } alu_ctrl_t;

  // NOR and NAND come from De Morgan: invert both inputs, then AND / OR.
  function automatic alu_ctrl_t decode_op(input logic [2:0] op);
    alu_ctrl_t c;
    c = '0;
    c.operation = ALU_AND;
    case (op)
      OP_AND:  c.operation = ALU_AND;
      OP_OR:   c.operation = ALU_OR;
      OP_ADD:  c.operation = ALU_ADD;
      OP_SUB: begin
        c.b_invert  = 1'b1;
        c.operation = ALU_ADD;
        c.carry_in  = 1'b1;
      end
      OP_NOR: begin
        c.a_invert  = 1'b1;
        c.b_invert  = 1'b1;
        c.operation = ALU_AND;
      end
      OP_NAND: begin
        c.a_invert  = 1'b1;
        c.b_invert  = 1'b1;
        c.operation = ALU_OR;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; last_grant=1 means requester 1 won last time.
module rr_arbiter_2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/sixty_four_bit_alu.sv
// Combinational ALU: optional input inversion, then AND / OR / ADD with carry-in.
module sixty_four_bit_alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic [1:0]       operation,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zf
);

  logic [WIDTH-1:0] aa, bb;
  logic [WIDTH:0]   sum;

  // Carry is only meaningful for the adder path; logic ops report 0.
  always_comb begin
    aa        = a_invert ? ~a : a;
    bb        = b_invert ? ~b : b;
    sum       = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, carry_in};
    result    = '0;
    carry_out = 1'b0;
    case (operation)
      ALU_AND: result = aa & bb;
      ALU_OR:  result = aa | bb;
      ALU_ADD: begin
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      default: result = '0;
    endcase
    zf = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; one op in flight at a time.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             last_grant;
  logic             grant0, grant1;
  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_zf;

  rr_arbiter_2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Grant never looks at ready, so valid -> ready is the only combinational path.
  assign req0_ready = ~reset & (state == IDLE) & grant0;
  assign req1_ready = ~reset & (state == IDLE) & grant1;

  assign ctrl = decode_op(op_q);

  sixty_four_bit_alu #(.WIDTH(WIDTH)) u_alu (
    .a         (a_q),
    .b         (b_q),
    .a_invert  (ctrl.a_invert),
    .b_invert  (ctrl.b_invert),
    .operation (ctrl.operation),
    .carry_in  (ctrl.carry_in),
    .result    (alu_result),
    .carry_out (alu_carry),
    .zf        (alu_zf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            op_q       <= grant0 ? req0_op : req1_op;
            a_q        <= grant0 ? req0_a  : req1_a;
            b_q        <= grant0 ? req0_b  : req1_b;
            id_q       <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          if (ctrl.illegal) begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zf;
            rsp_err    <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural arbitration/ALU model.
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_err;
  logic [W-1:0]  rsp_result;
  logic [CW-1:0] op_count;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { logic id; logic [W-1:0] res; logic c; logic z; logic e; } rsp_t;

  op_t  q0[$], q1[$];
  rsp_t sb[$];
  int   checks = 0, failures = 0;
  bit   run = 0, gaps = 0;
  int   rdy_mode = 0;           // 0: always ready, 1: random, 2: stalled
  bit   v0 = 0, v1 = 0;
  op_t  c0, c1;
  bit   idle_m = 1, last_m = 1, hs_pend = 0;
  int   age = 0, accepts = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  function automatic op_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    return o;
  endfunction

  // Reference semantics written from the op table with plain arithmetic.
  function automatic rsp_t model(input bit id, input op_t o);
    rsp_t r;
    logic [W:0] s;
    r.id = id; r.c = 1'b0; r.e = 1'b0; r.res = '0;
    case (o.op)
      3'd0: r.res = o.a & o.b;
      3'd1: r.res = o.a | o.b;
      3'd2: begin s = {1'b0, o.a} + {1'b0, o.b}; r.res = s[W-1:0]; r.c = s[W]; end
      3'd3: begin r.res = o.a - o.b; r.c = (o.a >= o.b); end
      3'd4: r.res = ~(o.a | o.b);
      3'd5: r.res = ~(o.a & o.b);
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: presents requests and tracks the expected handshake timing.
  always @(negedge clk) begin
    bit g0, g1;
    if (run && !reset) begin
      if (!v0 && q0.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin c0 = q0.pop_front(); v0 = 1; end
      if (!v1 && q1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin c1 = q1.pop_front(); v1 = 1; end
    end
    req0_valid = v0; req0_op = c0.op; req0_a = c0.a; req0_b = c0.b;
    req1_valid = v1; req1_op = c1.op; req1_a = c1.a; req1_b = c1.b;
    rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    #1;
    if (reset) begin
      chk("ready0_in_reset", W'(req0_ready), '0);
      chk("ready1_in_reset", W'(req1_ready), '0);
      idle_m = 1; last_m = 1; hs_pend = 0; v0 = 0; v1 = 0; age = 0;
    end else begin
      if (hs_pend) begin idle_m = 1; hs_pend = 0; end
      if (!idle_m) age++;
      g0 = idle_m && v0 && (!v1 || last_m);
      g1 = idle_m && v1 && (!v0 || !last_m);
      chk("req0_ready", W'(req0_ready), W'(g0));
      chk("req1_ready", W'(req1_ready), W'(g1));
      chk("rsp_valid", W'(rsp_valid), W'(!idle_m && age >= 2));
      if (g0) begin
        sb.push_back(model(1'b0, c0)); v0 = 0; last_m = 0; idle_m = 0; age = 0; accepts++;
      end else if (g1) begin
        sb.push_back(model(1'b1, c1)); v1 = 0; last_m = 1; idle_m = 0; age = 0; accepts++;
      end else if (!idle_m && age >= 2 && rsp_ready) begin
        hs_pend = 1;
      end
    end
  end

  // Monitor: compares each completed response against the scoreboard.
  rsp_t prev;
  bit   held = 0;
  int   mcount = 0;
  always @(negedge clk) begin
    rsp_t e;
    #1;
    if (reset) begin
      sb.delete(); mcount = 0; held = 0;
    end else begin
      chk("op_count", W'(op_count), W'(mcount));
      if (held) begin
        chk("hold_valid",  W'(rsp_valid), W'(1));
        chk("hold_id",     W'(rsp_id), W'(prev.id));
        chk("hold_result", rsp_result, prev.res);
        chk("hold_carry",  W'(rsp_carry), W'(prev.c));
        chk("hold_zero",   W'(rsp_zero), W'(prev.z));
        chk("hold_err",    W'(rsp_err), W'(prev.e));
      end
      held = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual id=%0d result=%0h required none", rsp_id, rsp_result);
          end else begin
            e = sb.pop_front();
            chk("rsp_id",     W'(rsp_id), W'(e.id));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_carry",  W'(rsp_carry), W'(e.c));
            chk("rsp_zero",   W'(rsp_zero), W'(e.z));
            chk("rsp_err",    W'(rsp_err), W'(e.e));
          end
          mcount++;
        end else begin
          held = 1;
          prev.id = rsp_id; prev.res = rsp_result; prev.c = rsp_carry; prev.z = rsp_zero; prev.e = rsp_err;
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_rsp_valid",  W'(rsp_valid), '0);
    chk("rst_rsp_id",     W'(rsp_id), '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_carry",  W'(rsp_carry), '0);
    chk("rst_rsp_zero",   W'(rsp_zero), '0);
    chk("rst_rsp_err",    W'(rsp_err), '0);
    chk("rst_op_count",   W'(op_count), '0);
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || !idle_m || sb.size() > 0) && k < 400) begin
      @(negedge clk); #2; k++;
    end
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
    end
  endtask

  task automatic wait_accept(input int n);
    int k = 0;
    while (accepts == n && k < 50) begin @(negedge clk); #2; k++; end
    checks++;
    if (accepts == n) begin
      failures++;
      $display("FAIL accept_timeout actual accepts=%0d required >%0d", accepts, n);
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return ONES;
      2: return W'(1);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    int n;
    c0 = mk(3'd0, '0, '0);
    c1 = mk(3'd0, '0, '0);
    reset_dut();
    run = 1; rdy_mode = 0; gaps = 0;

    q0.push_back(mk(3'd2, W'(1), ONES));
    drain();

    q1.push_back(mk(3'd0, W'(1), ONES));
    q1.push_back(mk(3'd1, W'(1), ONES));
    drain();

    reset_dut();
    q0.push_back(mk(3'd3, W'(5), W'(3)));
    q1.push_back(mk(3'd4, '0, '0));
    drain();

    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(3'd2, rnd_operand(), rnd_operand()));
      q1.push_back(mk(3'd3, rnd_operand(), rnd_operand()));
    end
    drain();

    rdy_mode = 2;
    n = accepts;
    q0.push_back(mk(3'd5, rnd_operand(), rnd_operand()));
    wait_accept(n);
    repeat (7) @(negedge clk);
    rdy_mode = 0;
    drain();

    q1.push_back(mk(3'd7, ONES, ONES));
    drain();

    n = accepts;
    q0.push_back(mk(3'd2, W'(7), W'(9)));
    wait_accept(n);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #2;
    chk("exec_rst_valid",  W'(rsp_valid), '0);
    chk("exec_rst_result", rsp_result, '0);
    chk("exec_rst_count",  W'(op_count), '0);
    q0.push_back(mk(3'd2, W'(2), W'(3)));
    q1.push_back(mk(3'd1, W'(4), W'(8)));
    drain();

    rdy_mode = 1; gaps = 1;
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand()));
      q1.push_back(mk(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand()));
    end
    drain();
    rdy_mode = 0; gaps = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the team's combinational 64-bit ALU (sixty_four_bit_alu: a_invert, b_invert, 2-bit operation, carry_in, result, carry_out, zf) between two requesters.
- Round-robin arbitration over a valid/ready request interface.
- Translates a 3-bit op code into the ALU control lines.
- Registers operands and result, and returns tagged responses on a single valid/ready response port.
- Sits between the execute-stage issue logic and the shared ALU.

Parameters:
WIDTH, 64, operand/result width; must match the ALU instance.
CNT_W, 32, width of the completed-operation counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle when valid & ready.
req0_op  in  3  requester 0 op code.
req0_a  in  WIDTH  requester 0 operand a.
req0_b  in  WIDTH  requester 0 operand b.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response when valid & ready.
rsp_id  out  1  requester index of the response.
rsp_result  out  WIDTH  ALU result.
rsp_carry  out  1  ALU carry_out.
rsp_zero  out  1  ALU zf.
rsp_err  out  1  illegal op code.
op_count  out  CNT_W  responses completed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Op decode, as {a_invert, b_invert, operation, carry_in}:
  - 000 AND = 0,0,00,0
  - 001 OR = 0,0,01,0
  - 010 ADD = 0,0,10,0
  - 011 SUB = 0,1,10,1
  - 100 NOR = 1,1,00,0
  - 101 NAND = 1,1,01,0
  - 110/111 illegal: ALU is not consulted; result=0, carry=0, zero=1, err=1.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: reqN_ready = grantN; all other states: both readys 0.
    - On accept: latch op, a, b and id into operand registers; go to EXEC.
  - EXEC: ALU driven combinationally from the operand registers; result, carry, zero and err are captured into response registers at the end of the cycle; go to RESP.
  - RESP: rsp_valid=1; outputs stable until the handshake.
    - On rsp_valid & rsp_ready: op_count += 1; go to IDLE.
    - Otherwise hold.
- Latency: accept in cycle N gives rsp_valid in cycle N+2. Minimum issue interval is 3 cycles (rsp_ready held high).
- Arbitration:
  - Only one request valid: grant it.
  - Both valid: grant the requester not granted last (last_grant register).
  - last_grant updates only on an actual accept; initial value after reset is 1, so requester 0 wins first.
  - Grant depends only on the valid signals and last_grant, never on ready (no combinational loop).
  - A requester must hold valid and payload stable until accepted; the block does not check this.
- Width: carry and zero come straight from the ALU. No sign extension; SUB carry=1 means no borrow.
- Simultaneous events: reqs arriving during EXEC/RESP are ignored (ready=0) and wait. A rsp_ready without rsp_valid has no effect.
- Reset (any state, including mid-EXEC/RESP):
  - In-flight op discarded; state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0, op_count=0, last_grant=1.
  - req0_ready and req1_ready are 0 during the reset cycle.

Decomposition:
- Package alu_ctrl_pkg:
  - Op code constants OP_AND..OP_NAND.
  - ALU operation encodings ALU_AND=00, ALU_OR=01, ALU_ADD=10.
  - FSM state encoding IDLE/EXEC/RESP.
  - Decode function op -> {a_invert, b_invert, operation, carry_in, illegal}.
- Sub-module rr_arbiter_2: valid0, valid1, last_grant in; grant0, grant1 out. Purely combinational.
- The ALU is instantiated once inside alu_arbiter.

Test Plan:
- Req0 ADD, a=0x0000000000000001, b=0xFFFFFFFFFFFFFFFF -> two cycles after accept: rsp_result=0, carry=1, zero=1, id=0, err=0.
- Same operands with AND then OR, issued back-to-back from req1 -> results 0x1 (zero=0) then 0xFFFFFFFFFFFFFFFF; op_count 1 then 2; ready low during EXEC/RESP.
- Req0 SUB 5-3 and req1 NOR 0,0 asserted together from reset -> req0 served first (result 2, carry 1), then req1 (result 0xFFFFFFFFFFFFFFFF).
- Both requesters held valid for 4 operations -> grants alternate 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> response held stable, both readys 0; release -> single handshake, op_count +1.
- Op 111 -> rsp_err=1, result=0, zero=1. Then reset asserted during EXEC of a pending ADD -> no response ever appears; all outputs 0; next request is granted to req0.
